// File: rtl/imm_gen_pkg.sv
// Shared immediate-type codes and parameter checks for the pipelined immediate generator.
package imm_gen_pkg;

  localparam logic [2:0] IMM_I     = 3'b000;
  localparam logic [2:0] IMM_S     = 3'b001;
  localparam logic [2:0] IMM_B     = 3'b010;
  localparam logic [2:0] IMM_U     = 3'b011;
  localparam logic [2:0] IMM_J     = 3'b100;
  localparam logic [2:0] IMM_Z     = 3'b101;
  localparam logic [2:0] IMM_SHAMT = 3'b110;
  localparam logic [2:0] IMM_RSV   = 3'b111;

  function automatic bit xlen_legal(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction: builds a 32-bit field, then sign-extends it to XLEN.
module imm_extract
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      imm_type,
  input  logic [31:7]     inst,
  output logic [XLEN-1:0] imm,
  output logic            err
);

  // Zero-extended formats keep bit 31 clear, so one signed extension serves every type.
  logic [31:0] field;

  always_comb begin
    field = '0;
    err   = 1'b0;
    case (imm_type)
      IMM_I:     field = {{20{inst[31]}}, inst[31:20]};
      IMM_S:     field = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:     field = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:     field = {inst[31:12], 12'b0};
      IMM_J:     field = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      IMM_Z:     field = {27'b0, inst[19:15]};
      IMM_SHAMT: field = (XLEN == 64) ? {26'b0, inst[25:20]} : {27'b0, inst[24:20]};
      default:   err   = 1'b1;
    endcase
    imm = XLEN'($signed(field));
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: valid/ready input, registered head entry plus one skid entry.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             flush_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [2:0]       imm_type_in,
  input  logic [31:7]      inst_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [XLEN-1:0]  imm_out,
  output logic [TAG_W-1:0] tag_out,
  output logic             imm_err_out
);

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("imm_gen_pipe: TAG_W must be at least 1");
  end

  logic [XLEN-1:0]  ext_imm;
  logic             ext_err;

  logic             main_v, main_v_n, skid_v, skid_v_n, rdy_q;
  logic [XLEN-1:0]  main_imm, main_imm_n, skid_imm, skid_imm_n;
  logic [TAG_W-1:0] main_tag, main_tag_n, skid_tag, skid_tag_n;
  logic             main_err, main_err_n, skid_err, skid_err_n;
  logic             acc, pop;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .imm_type (imm_type_in),
    .inst     (inst_in),
    .imm      (ext_imm),
    .err      (ext_err)
  );

  assign acc = valid_in & rdy_q & ~flush_in;
  assign pop = main_v & ready_in;

  // The main entry is always the head; skid is only ever valid while main is.
  always_comb begin
    main_v_n   = main_v;
    main_imm_n = main_imm;
    main_tag_n = main_tag;
    main_err_n = main_err;
    skid_v_n   = skid_v;
    skid_imm_n = skid_imm;
    skid_tag_n = skid_tag;
    skid_err_n = skid_err;
    if (flush_in) begin
      main_v_n = 1'b0;
      skid_v_n = 1'b0;
    end else if (pop) begin
      if (skid_v) begin
        main_imm_n = skid_imm;
        main_tag_n = skid_tag;
        main_err_n = skid_err;
        skid_v_n   = 1'b0;
      end else if (acc) begin
        main_imm_n = ext_imm;
        main_tag_n = tag_in;
        main_err_n = ext_err;
      end else begin
        main_v_n = 1'b0;
      end
    end else if (acc) begin
      if (!main_v) begin
        main_v_n   = 1'b1;
        main_imm_n = ext_imm;
        main_tag_n = tag_in;
        main_err_n = ext_err;
      end else begin
        skid_v_n   = 1'b1;
        skid_imm_n = ext_imm;
        skid_tag_n = tag_in;
        skid_err_n = ext_err;
      end
    end
  end

  // ready is registered from the next occupancy so it never depends on ready_in combinationally.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      main_v   <= 1'b0;
      main_imm <= '0;
      main_tag <= '0;
      main_err <= 1'b0;
      skid_v   <= 1'b0;
      skid_imm <= '0;
      skid_tag <= '0;
      skid_err <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      main_v   <= main_v_n;
      main_imm <= main_imm_n;
      main_tag <= main_tag_n;
      main_err <= main_err_n;
      skid_v   <= skid_v_n;
      skid_imm <= skid_imm_n;
      skid_tag <= skid_tag_n;
      skid_err <= skid_err_n;
      rdy_q    <= ~(main_v_n & skid_v_n);
    end
  end

  assign ready_out   = rdy_q;
  assign valid_out   = main_v;
  assign imm_out     = main_imm;
  assign tag_out     = main_tag;
  assign imm_err_out = main_err;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe (XLEN=32): streamed vector table plus backpressure, flush and reset sequences.
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        valid_in;
  logic        ready_out;
  logic [2:0]  imm_type;
  logic [31:0] inst_word;
  logic [4:0]  tag_in;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] imm_out;
  logic [4:0]  tag_out;
  logic        imm_err;

  int total = 0;
  int bad   = 0;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .flush_in    (flush),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .imm_type_in (imm_type),
    .inst_in     (inst_word[31:7]),
    .tag_in      (tag_in),
    .valid_out   (valid_out),
    .ready_in    (ready_in),
    .imm_out     (imm_out),
    .tag_out     (tag_out),
    .imm_err_out (imm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  ty;
    logic [31:0] inst;
    logic [4:0]  tag;
    logic [31:0] imm;
    logic        err;
  } vec_t;

  vec_t vecs[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] ty, input logic [31:0] w, input logic [4:0] t);
    valid_in  = v;
    imm_type  = ty;
    inst_word = w;
    tag_in    = t;
  endtask

  initial begin
    vecs[0]  = '{IMM_I,     32'h12345678, 5'd3,  32'h00000123, 1'b0};
    vecs[1]  = '{IMM_S,     32'h12345678, 5'd4,  32'h0000012C, 1'b0};
    vecs[2]  = '{IMM_U,     32'h12345678, 5'd5,  32'h12345000, 1'b0};
    vecs[3]  = '{IMM_I,     32'hFFF00093, 5'd6,  32'hFFFFFFFF, 1'b0};
    vecs[4]  = '{IMM_B,     32'hFE000EE3, 5'd7,  32'hFFFFFFFC, 1'b0};
    vecs[5]  = '{IMM_J,     32'h0080006F, 5'd8,  32'h00000008, 1'b0};
    vecs[6]  = '{IMM_Z,     32'hFFFFFFFF, 5'd9,  32'h0000001F, 1'b0};
    vecs[7]  = '{IMM_SHAMT, 32'h02300000, 5'd10, 32'h00000003, 1'b0};
    vecs[8]  = '{IMM_RSV,   32'h12345678, 5'd11, 32'h00000000, 1'b1};
    vecs[9]  = '{IMM_S,     32'hFE000FA3, 5'd12, 32'hFFFFFFFF, 1'b0};
    vecs[10] = '{IMM_U,     32'h80000037, 5'd13, 32'h80000000, 1'b0};
    vecs[11] = '{IMM_B,     32'h00000080, 5'd14, 32'h00000800, 1'b0};

    rst = 1'b1; flush = 1'b0; ready_in = 1'b1;
    drive(1'b0, IMM_I, 32'h0, 5'd0);
    step(); step();
    check("rst_valid", 64'(valid_out), 64'd0);
    check("rst_imm",   64'(imm_out),   64'd0);
    check("rst_tag",   64'(tag_out),   64'd0);
    check("rst_err",   64'(imm_err),   64'd0);
    check("rst_ready", 64'(ready_out), 64'd0);
    rst = 1'b0;
    step();
    check("ready_after_rst", 64'(ready_out), 64'd1);
    check("idle_valid",      64'(valid_out), 64'd0);

    // Streaming: each vector appears one cycle after it is presented, occupancy stays at 1.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, vecs[i].ty, vecs[i].inst, vecs[i].tag);
      step();
      check($sformatf("vec%0d_valid", i), 64'(valid_out), 64'd1);
      check($sformatf("vec%0d_imm", i),   64'(imm_out),   64'(vecs[i].imm));
      check($sformatf("vec%0d_tag", i),   64'(tag_out),   64'(vecs[i].tag));
      check($sformatf("vec%0d_err", i),   64'(imm_err),   64'(vecs[i].err));
      check($sformatf("vec%0d_ready", i), 64'(ready_out), 64'd1);
    end
    drive(1'b0, IMM_I, 32'h0, 5'd0);
    step();
    check("drain_valid", 64'(valid_out), 64'd0);

    // Backpressure: three beats offered, two taken, released in order.
    ready_in = 1'b0;
    drive(1'b1, IMM_I, 32'h00A00000, 5'd1);
    step();
    check("bp1_ready", 64'(ready_out), 64'd1);
    drive(1'b1, IMM_I, 32'h00B00000, 5'd2);
    step();
    check("bp2_ready", 64'(ready_out), 64'd0);
    drive(1'b1, IMM_I, 32'h00C00000, 5'd3);
    step();
    check("bp3_ready", 64'(ready_out), 64'd0);
    check("bp3_head",  64'(imm_out),   64'h00A);
    drive(1'b0, IMM_I, 32'h0, 5'd0);
    ready_in = 1'b1;
    step();
    check("bp_out2_imm", 64'(imm_out),   64'h00B);
    check("bp_out2_tag", 64'(tag_out),   64'd2);
    check("bp_ready_up", 64'(ready_out), 64'd1);
    step();
    check("bp_empty", 64'(valid_out), 64'd0);

    // Flush with both entries full and a beat offered.
    ready_in = 1'b0;
    drive(1'b1, IMM_I, 32'h00100000, 5'd4);
    step();
    drive(1'b1, IMM_I, 32'h00200000, 5'd5);
    step();
    check("fl_full", 64'(ready_out), 64'd0);
    flush = 1'b1;
    drive(1'b1, IMM_I, 32'h00300000, 5'd6);
    step();
    check("fl_valid", 64'(valid_out), 64'd0);
    check("fl_ready", 64'(ready_out), 64'd1);
    flush = 1'b0;
    drive(1'b0, IMM_I, 32'h0, 5'd0);
    step();
    check("fl_nothing_taken", 64'(valid_out), 64'd0);

    // One entry held, then accept and consume in the same cycle.
    drive(1'b1, IMM_J, 32'h0080006F, 5'd7);
    step();
    ready_in = 1'b1;
    drive(1'b1, IMM_Z, 32'h000F8000, 5'd8);
    step();
    check("ac_valid", 64'(valid_out), 64'd1);
    check("ac_imm",   64'(imm_out),   64'h1F);
    check("ac_tag",   64'(tag_out),   64'd8);
    check("ac_ready", 64'(ready_out), 64'd1);
    drive(1'b0, IMM_I, 32'h0, 5'd0);
    step();
    check("ac_empty", 64'(valid_out), 64'd0);

    // Reserved type, then reset mid-stream.
    drive(1'b1, IMM_RSV, 32'hFFFFFFFF, 5'd9);
    step();
    check("rsv_imm", 64'(imm_out), 64'd0);
    check("rsv_err", 64'(imm_err), 64'd1);
    ready_in = 1'b0;
    drive(1'b1, IMM_I, 32'h12345678, 5'd10);
    step();
    rst = 1'b1;
    step();
    check("mrst_valid", 64'(valid_out), 64'd0);
    check("mrst_imm",   64'(imm_out),   64'd0);
    check("mrst_ready", 64'(ready_out), 64'd0);
    check("mrst_err",   64'(imm_err),   64'd0);
    rst = 1'b0;
    drive(1'b0, IMM_I, 32'h0, 5'd0);
    step();
    check("mrst_ready_up", 64'(ready_out), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
